// File: rtl/pipelined_addsub.sv
// ============================================================================
// Module   : pipelined_addsub
// Purpose  : Carry-pipelined add/subtract with valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_addsub #(
  parameter int DATA_WIDTH = 12,
  parameter int NUM_SEG    = 3
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RI,
  input  logic                  In_Valid_SI,
  output logic                  In_Ready_SO,
  input  logic [DATA_WIDTH-1:0] A_DI,
  input  logic [DATA_WIDTH-1:0] B_DI,
  input  logic                  Cin_DI,
  input  logic                  Sub_SI,
  input  logic                  Clr_SI,
  output logic                  Out_Valid_SO,
  input  logic                  Out_Ready_SI,
  output logic [DATA_WIDTH-1:0] Sum_DO,
  output logic                  Cout_DO,
  output logic                  Ovf_DO
);

  localparam int SEG_W = DATA_WIDTH / NUM_SEG;
  localparam int MSB   = DATA_WIDTH - 1;

  logic                  w_adv;
  logic                  w_accept;

  logic [NUM_SEG:0]      valid_d, valid_q;
  logic [DATA_WIDTH-1:0] a_d   [NUM_SEG];
  logic [DATA_WIDTH-1:0] a_q   [NUM_SEG];
  logic [DATA_WIDTH-1:0] b_d   [NUM_SEG];
  logic [DATA_WIDTH-1:0] b_q   [NUM_SEG];
  logic [NUM_SEG-1:0]    carry_d, carry_q;
  // Rank 0 carries an all-zero partial sum so every rank merges uniformly.
  logic [DATA_WIDTH-1:0] sum_d [NUM_SEG+1];
  logic [DATA_WIDTH-1:0] sum_q [NUM_SEG+1];
  logic                  cout_d, cout_q;
  logic                  ovf_d, ovf_q;

  logic [SEG_W:0]        w_seg    [NUM_SEG];
  logic [DATA_WIDTH-1:0] w_merged [NUM_SEG];

  assign w_adv       = ~valid_q[NUM_SEG] | Out_Ready_SI;
  assign In_Ready_SO = w_adv & ~Clr_SI;
  assign w_accept    = In_Valid_SI & In_Ready_SO;

  assign Out_Valid_SO = valid_q[NUM_SEG];
  assign Sum_DO       = sum_q[NUM_SEG];
  assign Cout_DO      = cout_q;
  assign Ovf_DO       = ovf_q;

  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    if (Clr_SI) begin
      valid_d = '0;
    end else if (w_adv) begin
      valid_d = {valid_q[NUM_SEG-1:0], w_accept};
    end

    sum_d[0] = '0;
    if (w_adv) begin
      a_d[0]     = A_DI;
      b_d[0]     = Sub_SI ? ~B_DI : B_DI;
      carry_d[0] = Sub_SI | Cin_DI;
    end

    // Rank k sums segment k-1 of the operands held by rank k-1.
    for (int k = 1; k <= NUM_SEG; k++) begin
      w_seg[k-1] = {1'b0, a_q[k-1][(k-1)*SEG_W +: SEG_W]}
                 + {1'b0, b_q[k-1][(k-1)*SEG_W +: SEG_W]}
                 + {{SEG_W{1'b0}}, carry_q[k-1]};
      w_merged[k-1] = sum_q[k-1];
      w_merged[k-1][(k-1)*SEG_W +: SEG_W] = w_seg[k-1][SEG_W-1:0];
      if (w_adv) begin
        sum_d[k] = w_merged[k-1];
      end
    end

    if (w_adv) begin
      for (int k = 1; k < NUM_SEG; k++) begin
        a_d[k]     = a_q[k-1];
        b_d[k]     = b_q[k-1];
        carry_d[k] = w_seg[k-1][SEG_W];
      end
      cout_d = w_seg[NUM_SEG-1][SEG_W];
      ovf_d  = (a_q[NUM_SEG-1][MSB] == b_q[NUM_SEG-1][MSB])
             & (w_merged[NUM_SEG-1][MSB] != a_q[NUM_SEG-1][MSB]);
    end
  end

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      valid_q <= '0;
      carry_q <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < NUM_SEG; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      for (int k = 0; k <= NUM_SEG; k++) begin
        sum_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

`default_nettype wire
